// File: rtl/gshare_predictor.sv
// Fetch-stage direction predictor: bimodal or gshare indexed saturating-counter table
// with speculative global history, mispredict recovery and a post-reset clearing sweep.
module gshare_predictor #(
   parameter int CNT_BIT = 2,
   parameter int BHT_IDX = 8,
   parameter int GHR_LEN = 8,
   parameter int MODE    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic [31:0]        pd_pc,
   input  logic [31:0]        pd_inst,
   input  logic               pd_en,
   output logic               pd_tk,
   output logic [31:0]        pd_off,
   output logic [GHR_LEN-1:0] pd_ghr,
   output logic               init_done,
   input  logic               fb_ena,
   input  logic [31:0]        fb_pc,
   input  logic [GHR_LEN-1:0] fb_ghr,
   input  logic               fb_tk,
   input  logic               fb_mispred
);

   localparam int                 ENTRIES = 1 << BHT_IDX;
   localparam logic [6:0]         OPC_BR  = 7'h63;
   localparam logic [6:0]         OPC_JAL = 7'h6f;
   localparam logic [CNT_BIT-1:0] WEAK_NT = {1'b0, {(CNT_BIT-1){1'b1}}};

   typedef enum logic {INIT, RUN} state_t;

   state_t             state;
   logic [CNT_BIT-1:0] bht [ENTRIES];
   logic [BHT_IDX-1:0] sweep;
   logic [GHR_LEN-1:0] ghr;

   logic [BHT_IDX-1:0] pd_idx;
   logic [BHT_IDX-1:0] fb_idx;
   logic [CNT_BIT-1:0] fb_cnt;
   logic               is_br;
   logic               is_jal;
   // One spare top bit lets the shift work unchanged for GHR_LEN = 1.
   logic [GHR_LEN:0]   ghr_shift;
   logic [GHR_LEN:0]   ghr_restore;
   logic               unused_bits;

   assign is_br  = (pd_inst[6:0] == OPC_BR);
   assign is_jal = (pd_inst[6:0] == OPC_JAL);

   always_comb begin
      pd_idx = pd_pc[BHT_IDX+1:2];
      fb_idx = fb_pc[BHT_IDX+1:2];
      if (MODE != 0) begin
         pd_idx = pd_idx ^ BHT_IDX'(ghr);
         fb_idx = fb_idx ^ BHT_IDX'(fb_ghr);
      end
   end

   always_comb begin
      pd_off = 32'd4;
      if (is_br) begin
         pd_off = {{19{pd_inst[31]}}, pd_inst[31], pd_inst[7], pd_inst[30:25],
                   pd_inst[11:8], 1'b0};
      end else if (is_jal) begin
         pd_off = {{11{pd_inst[31]}}, pd_inst[31], pd_inst[19:12], pd_inst[20],
                   pd_inst[30:21], 1'b0};
      end
   end

   assign pd_tk       = is_jal | (is_br & (state == RUN) & bht[pd_idx][CNT_BIT-1]);
   assign pd_ghr      = ghr;
   assign fb_cnt      = bht[fb_idx];
   assign ghr_shift   = {ghr, pd_tk};
   assign ghr_restore = {fb_ghr, fb_tk};
   assign unused_bits = ^{pd_pc[31:BHT_IDX+2], pd_pc[1:0], fb_pc[31:BHT_IDX+2], fb_pc[1:0],
                          ghr_shift[GHR_LEN], ghr_restore[GHR_LEN]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= INIT;
         sweep     <= '0;
         ghr       <= '0;
         init_done <= 1'b0;
      end else if (rdy) begin
         case (state)
            INIT: begin
               bht[sweep] <= WEAK_NT;
               sweep      <= sweep + 1'b1;
               if (sweep == '1) begin
                  state     <= RUN;
                  init_done <= 1'b1;
               end
            end
            RUN: begin
               if (fb_ena) begin
                  if (fb_tk && (fb_cnt != '1))
                     bht[fb_idx] <= fb_cnt + 1'b1;
                  else if (!fb_tk && (fb_cnt != '0))
                     bht[fb_idx] <= fb_cnt - 1'b1;
               end
               // Recovery wins over a same-cycle speculative shift.
               if (fb_ena && fb_mispred)
                  ghr <= ghr_restore[GHR_LEN-1:0];
               else if (pd_en && is_br)
                  ghr <= ghr_shift[GHR_LEN-1:0];
            end
         endcase
      end
   end

endmodule
